// File: rtl/neo_detector_adaptive.sv
// NEO spike detector: |x[n-1]^2 - x[n]*x[n-2]| with a threshold learned from a
// training window (or supplied directly), refractory holdoff and spike counting.
module neo_detector_adaptive #(
  parameter int DATA_W      = 16,
  parameter int NEO_W       = 24,
  parameter int TRAIN_LOG2  = 4,
  parameter int THR_SCALE   = 4,
  parameter int REFRACT_LEN = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] data_in,
  input  logic                     thr_mode,
  input  logic [NEO_W-1:0]         thr_fixed,
  input  logic                     retrain,
  output logic                     neo_valid,
  output logic [NEO_W-1:0]         neo_out,
  output logic                     spike_pulse,
  output logic [NEO_W-1:0]         threshold,
  output logic                     trained,
  output logic [15:0]              spike_count
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int DIFF_W = PROD_W + 1;
  localparam int WIDE_W = (DIFF_W > NEO_W) ? DIFF_W : NEO_W;
  localparam int ACC_W  = NEO_W + TRAIN_LOG2;
  localparam int FILL_W = TRAIN_LOG2 + 1;
  localparam int HOLD_W = (REFRACT_LEN > 0) ? $clog2(REFRACT_LEN + 1) : 1;
  localparam int SCL_W  = NEO_W + 32;
  localparam logic [NEO_W-1:0]  NEO_MAX   = '1;
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'((1 << TRAIN_LOG2) - 1);

  typedef enum logic [1:0] {TRAIN, DETECT, HOLDOFF} state_t;

  state_t                     state, state_next;
  logic signed [DATA_W-1:0]   x0, x1;
  logic [1:0]                 samp_cnt;
  logic                       s1_valid;
  logic signed [PROD_W-1:0]   prod_sq, prod_x;
  logic signed [DIFF_W-1:0]   diff;
  logic [DIFF_W-1:0]          mag;
  logic [WIDE_W-1:0]          mag_wide;
  logic [NEO_W-1:0]           neo_next;
  logic [ACC_W-1:0]           acc, acc_sum;
  logic [FILL_W-1:0]          fill;
  logic [NEO_W-1:0]           mean;
  logic [SCL_W-1:0]           scaled;
  logic [NEO_W-1:0]           thr_next, thr_active;
  logic [HOLD_W-1:0]          hold, hold_next;
  logic                       train_last, trained_next, eligible, spike_now;

  // Products are formed from the post-shift window at the acceptance edge, so
  // only two past samples need to be stored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x0       <= '0;
      x1       <= '0;
      samp_cnt <= '0;
      s1_valid <= 1'b0;
      prod_sq  <= '0;
      prod_x   <= '0;
    end else begin
      s1_valid <= in_valid && (samp_cnt == 2'd2);
      if (in_valid) begin
        x1      <= x0;
        x0      <= data_in;
        prod_sq <= x0 * x0;
        prod_x  <= data_in * x1;
      end
      if (retrain)
        samp_cnt <= '0;
      else if (in_valid && samp_cnt != 2'd2)
        samp_cnt <= samp_cnt + 2'd1;
    end
  end

  always_comb begin
    diff     = DIFF_W'(prod_sq) - DIFF_W'(prod_x);
    mag      = diff[DIFF_W-1] ? DIFF_W'(-diff) : DIFF_W'(diff);
    mag_wide = WIDE_W'(mag);
    neo_next = (mag_wide > WIDE_W'(NEO_MAX)) ? NEO_MAX : mag_wide[NEO_W-1:0];

    acc_sum    = acc + ACC_W'(neo_next);
    mean       = acc_sum[ACC_W-1:TRAIN_LOG2];
    scaled     = SCL_W'(mean) * SCL_W'(THR_SCALE);
    thr_next   = (scaled > SCL_W'(NEO_MAX)) ? NEO_MAX : scaled[NEO_W-1:0];
    train_last = !trained && (fill == FILL_LAST);

    thr_active = thr_mode ? thr_fixed : threshold;
    eligible   = (state == DETECT) || (state == TRAIN && thr_mode);
    spike_now  = s1_valid && !retrain && eligible && (neo_next > thr_active);
  end

  // Holdoff is tracked by its own counter so fixed-threshold detection can run
  // while training is still accumulating; state is derived from counter+trained.
  always_comb begin
    hold_next = hold;
    if (spike_now)
      hold_next = HOLD_W'(REFRACT_LEN);
    else if (hold != '0)
      hold_next = hold - HOLD_W'(1);
    trained_next = trained | train_last;
    if (hold_next != '0)
      state_next = HOLDOFF;
    else if (trained_next)
      state_next = DETECT;
    else
      state_next = TRAIN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= TRAIN;
      neo_valid   <= 1'b0;
      neo_out     <= '0;
      spike_pulse <= 1'b0;
      threshold   <= '0;
      trained     <= 1'b0;
      spike_count <= '0;
      acc         <= '0;
      fill        <= '0;
      hold        <= '0;
    end else begin
      neo_valid   <= s1_valid;
      spike_pulse <= 1'b0;
      if (s1_valid)
        neo_out <= neo_next;
      if (retrain) begin
        acc       <= '0;
        fill      <= '0;
        trained   <= 1'b0;
        threshold <= '0;
        hold      <= '0;
        state     <= TRAIN;
      end else if (s1_valid) begin
        if (spike_now) begin
          spike_pulse <= 1'b1;
          if (spike_count != '1)
            spike_count <= spike_count + 16'd1;
        end
        if (!trained) begin
          acc  <= acc_sum;
          fill <= fill + FILL_W'(1);
          if (train_last) begin
            threshold <= thr_next;
            trained   <= 1'b1;
          end
        end
        hold  <= hold_next;
        state <= state_next;
      end
    end
  end

endmodule

// File: tb/tb_neo_detector_adaptive.sv
// Bench for neo_detector_adaptive: directed scenarios plus random traffic,
// all compared each cycle against a sample-level reference model.
module tb_neo_detector_adaptive;
  localparam int DATA_W      = 16;
  localparam int NEO_W       = 24;
  localparam int TRAIN_LOG2  = 4;
  localparam int THR_SCALE   = 4;
  localparam int REFRACT_LEN = 8;
  localparam int TRAIN_N     = 1 << TRAIN_LOG2;
  localparam longint unsigned NEO_MAX = (64'd1 << NEO_W) - 1;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     in_valid = 1'b0;
  logic signed [DATA_W-1:0] data_in = '0;
  logic                     thr_mode = 1'b0;
  logic [NEO_W-1:0]         thr_fixed = '0;
  logic                     retrain = 1'b0;
  logic                     neo_valid, spike_pulse, trained;
  logic [NEO_W-1:0]         neo_out, threshold;
  logic [15:0]              spike_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  neo_detector_adaptive #(
    .DATA_W(DATA_W), .NEO_W(NEO_W), .TRAIN_LOG2(TRAIN_LOG2),
    .THR_SCALE(THR_SCALE), .REFRACT_LEN(REFRACT_LEN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .data_in(data_in),
    .thr_mode(thr_mode), .thr_fixed(thr_fixed), .retrain(retrain),
    .neo_valid(neo_valid), .neo_out(neo_out), .spike_pulse(spike_pulse),
    .threshold(threshold), .trained(trained), .spike_count(spike_count)
  );

  // Reference model: last three samples, values due one edge after launch.
  typedef struct { longint unsigned val; int due; } pend_t;
  longint          samp_q[$];
  pend_t           pend_q[$];
  int              nsamp, cyc;
  bit              m_valid, m_spike, m_trained;
  longint unsigned m_neo, m_thr, m_acc;
  int              m_count, m_n, m_hold;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    samp_q.delete();
    repeat (3) samp_q.push_back(0);
    pend_q.delete();
    nsamp = 0; cyc = 0;
    m_valid = 0; m_spike = 0; m_trained = 0;
    m_neo = 0; m_thr = 0; m_acc = 0;
    m_count = 0; m_n = 0; m_hold = 0;
  endtask

  task automatic model_edge(input bit v, input longint d, input bit r,
                            input bit mode, input longint unsigned fixed);
    bit              emerge;
    longint unsigned val, thr, mag;
    longint          psi;
    bit              spike;
    pend_t           p;
    emerge = 0; val = 0;
    cyc++;
    if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
      val = pend_q[0].val;
      emerge = 1;
      void'(pend_q.pop_front());
    end
    if (v) begin
      samp_q.push_back(d);
      void'(samp_q.pop_front());
      if (nsamp >= 2) begin
        psi = samp_q[1] * samp_q[1] - samp_q[2] * samp_q[0];
        mag = (psi < 0) ? longint'(-psi) : longint'(psi);
        if (mag > NEO_MAX) mag = NEO_MAX;
        p.val = mag; p.due = cyc + 1;
        pend_q.push_back(p);
      end
    end
    if (r) nsamp = 0;
    else if (v && nsamp < 2) nsamp++;

    m_valid = emerge;
    m_spike = 0;
    if (emerge) m_neo = val;
    if (r) begin
      m_acc = 0; m_n = 0; m_trained = 0; m_thr = 0; m_hold = 0;
    end else if (emerge) begin
      thr   = mode ? fixed : m_thr;
      spike = (m_hold == 0) && (m_trained || mode) && (val > thr);
      if (spike) begin
        m_spike = 1;
        if (m_count < 65535) m_count++;
        m_hold = REFRACT_LEN;
      end else if (m_hold > 0) begin
        m_hold--;
      end
      if (!m_trained) begin
        m_acc += val;
        m_n++;
        if (m_n == TRAIN_N) begin
          m_thr = (m_acc >> TRAIN_LOG2) * THR_SCALE;
          if (m_thr > NEO_MAX) m_thr = NEO_MAX;
          m_trained = 1;
        end
      end
    end
  endtask

  task automatic compare_outputs();
    check("neo_valid", neo_valid, m_valid);
    check("spike_pulse", spike_pulse, m_spike);
    check("trained", trained, m_trained);
    check("threshold", threshold, m_thr);
    check("spike_count", spike_count, m_count);
    check("neo_out", neo_out, m_neo);
  endtask

  task automatic drive(input bit v, input longint d, input bit r);
    logic [63:0] dv;
    @(negedge clk);
    dv = d;
    in_valid = v;
    data_in  = dv[DATA_W-1:0];
    retrain  = r;
    model_edge(v, longint'(data_in), r, thr_mode, thr_fixed);
    @(posedge clk);
    #1;
    compare_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0);
  endtask

  task automatic ramp();
    for (int k = -17; k <= 0; k++) drive(1, k, 0);
  endtask

  task automatic zeros(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_neo_valid"}, neo_valid, 0);
    check({tag, "_neo_out"}, neo_out, 0);
    check({tag, "_spike_pulse"}, spike_pulse, 0);
    check({tag, "_threshold"}, threshold, 0);
    check({tag, "_trained"}, trained, 0);
    check({tag, "_spike_count"}, spike_count, 0);
  endtask

  initial begin
    logic [15:0] rnd;
    longint      d;
    bit          v, r;

    model_reset();
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Constant input: every NEO is 0, threshold trains to 0, nothing spikes.
    for (int i = 0; i < 30; i++) drive(1, 100, 0);
    idle(3);
    check("const_threshold", threshold, 0);
    check("const_trained", trained, 1);
    check("const_count", spike_count, 0);

    // Ramp trains threshold 4; a single 10000 window then spikes once.
    drive(0, 0, 1);
    ramp();
    idle(2);
    check("ramp_threshold", threshold, 4);
    check("ramp_trained", trained, 1);
    drive(1, 0, 0); drive(1, 0, 0); drive(1, 100, 0); drive(1, 0, 0); drive(1, 0, 0);
    idle(3);
    check("single_spike_count", spike_count, 1);
    zeros(10);

    // Ten consecutive 10000 windows: spikes on the 1st and the 10th only.
    for (int i = 0; i < 11; i++) drive(1, (i % 2 == 0) ? 100 : 0, 0);
    idle(3);
    check("holdoff_count", spike_count, 3);
    zeros(10);

    // Extreme samples saturate the NEO output.
    drive(1, 32767, 0); drive(1, -32768, 0); drive(1, -32768, 0);
    idle(2);
    check("sat_neo_out", neo_out, NEO_MAX);
    check("sat_count", spike_count, 4);
    zeros(10);

    // Fixed threshold spikes before training completes.
    idle(2);
    thr_mode = 1'b1;
    thr_fixed = 24'd5000;
    drive(0, 0, 1);
    drive(1, 0, 0); drive(1, 0, 0); drive(1, 100, 0); drive(1, 0, 0); drive(1, 0, 0);
    idle(3);
    check("fixed_count", spike_count, 5);
    check("fixed_trained", trained, 0);
    thr_mode = 1'b0;

    // Retrain from DETECT keeps spike_count and relearns the same threshold.
    idle(2);
    drive(0, 0, 1);
    ramp();
    idle(2);
    check("pre_retrain_trained", trained, 1);
    zeros(3);
    idle(2);
    drive(0, 0, 1);
    check("retrain_trained", trained, 0);
    check("retrain_threshold", threshold, 0);
    ramp();
    idle(2);
    check("retrained_threshold", threshold, 4);
    check("retrained_count", spike_count, 5);

    // Random traffic, mode changes and occasional retrain.
    for (int i = 0; i < 700; i++) begin
      if (i % 90 == 45) thr_mode = ~thr_mode;
      if (i % 60 == 0) thr_fixed = NEO_W'($urandom_range(0, 60000));
      v = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 15) == 0) begin
        rnd = 16'($urandom);
        d = longint'($signed(rnd));
      end else begin
        d = longint'($urandom_range(0, 400)) - 200;
      end
      r = ($urandom_range(0, 119) == 0);
      drive(v, d, r);
    end
    thr_mode = 1'b0;

    // Asynchronous reset in the middle of a stream.
    @(negedge clk);
    in_valid = 1'b1;
    data_in  = 16'sd300;
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < 24; i++) drive(1, 7, 0);
    idle(3);
    check("post_reset_trained", trained, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
